// File: rtl/rc4_phase_sequencer.sv
// rc4_phase_sequencer
// Sequences a chain of NUM_PHASES sub-engines (init, shuffle, decrypt, ...)
// over a range of key candidates. Each phase gets a one-cycle start pulse and
// the shared memory mux selects it until its finish strobe arrives. After the
// last phase, the verdict (key_pass) either ends the search or advances the key.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   start         - begin a search (IDLE only)
//   abort         - cancel an in-progress search
//   done_ack      - release DONE and clear the flags
//   phase_finish  - per-engine finish strobes
//   key_pass      - verdict of the last engine, valid with its finish strobe
//   phase_start   - per-engine one-cycle start pulse
//   mem_sel       - shared-memory select: 0 when idle, p+1 during phase p
//   key           - current key candidate
//   busy, done, key_found, exhausted, timeout_err - status
module rc4_phase_sequencer #(
  parameter int    NUM_PHASES     = 4,
  parameter int    KEY_WIDTH      = 24,
  parameter longint KEY_FIRST     = 0,
  parameter longint KEY_LAST      = (longint'(1) << KEY_WIDTH) - 1,
  parameter int    TIMEOUT_CYCLES = 0,
  localparam int   SEL_WIDTH      = $clog2(NUM_PHASES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  done_ack,
  input  logic [NUM_PHASES-1:0] phase_finish,
  input  logic                  key_pass,
  output logic [NUM_PHASES-1:0] phase_start,
  output logic [SEL_WIDTH-1:0]  mem_sel,
  output logic [KEY_WIDTH-1:0]  key,
  output logic                  busy,
  output logic                  done,
  output logic                  key_found,
  output logic                  exhausted,
  output logic                  timeout_err
);

  localparam int PH_W = $clog2(NUM_PHASES);
  // Watchdog counts 0..TIMEOUT_CYCLES-1 cycles spent in PWAIT.
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [PH_W-1:0]      LAST_PH = PH_W'(NUM_PHASES - 1);
  localparam logic [KEY_WIDTH-1:0] KEY_F   = KEY_WIDTH'(KEY_FIRST);
  localparam logic [KEY_WIDTH-1:0] KEY_L   = KEY_WIDTH'(KEY_LAST);
  localparam logic [WD_W-1:0]      WD_LIM  = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PSTART,
    PWAIT,
    NEXT_KEY,
    DONE
  } state_t;

  state_t               state, state_n;
  logic [PH_W-1:0]      phase, phase_n;
  logic [KEY_WIDTH-1:0] key_n;
  logic [WD_W-1:0]      wdog, wdog_n;
  logic                 found_n, exh_n, to_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= '0;
      key         <= KEY_F;
      wdog        <= '0;
      key_found   <= 1'b0;
      exhausted   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      key         <= key_n;
      wdog        <= wdog_n;
      key_found   <= found_n;
      exhausted   <= exh_n;
      timeout_err <= to_n;
    end
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    key_n   = key;
    wdog_n  = wdog;
    found_n = key_found;
    exh_n   = exhausted;
    to_n    = timeout_err;
    case (state)
      IDLE: begin
        if (start) begin
          key_n   = KEY_F;
          phase_n = '0;
          state_n = PSTART;
        end
      end
      PSTART: begin
        // Clear the watchdog so it reads 0 on the first PWAIT cycle.
        wdog_n = '0;
        if (abort) state_n = IDLE;
        else       state_n = PWAIT;
      end
      PWAIT: begin
        if (abort) begin
          state_n = IDLE;
        end else if (phase_finish[phase]) begin
          // A finish on the watchdog's last cycle still counts as a finish.
          if (phase != LAST_PH) begin
            phase_n = phase + 1'b1;
            state_n = PSTART;
          end else if (key_pass) begin
            found_n = 1'b1;
            state_n = DONE;
          end else if (key == KEY_L) begin
            exh_n   = 1'b1;
            state_n = DONE;
          end else begin
            state_n = NEXT_KEY;
          end
        end else if (TIMEOUT_CYCLES > 0) begin
          if (wdog == WD_LIM) begin
            to_n    = 1'b1;
            state_n = DONE;
          end else begin
            wdog_n = wdog + 1'b1;
          end
        end
      end
      NEXT_KEY: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          // Only reached when key != KEY_LAST, so this never wraps.
          key_n   = key + 1'b1;
          phase_n = '0;
          state_n = PSTART;
        end
      end
      DONE: begin
        if (done_ack) begin
          found_n = 1'b0;
          exh_n   = 1'b0;
          to_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs decode registered state only.
  always_comb begin
    phase_start = '0;
    if (state == PSTART) phase_start[phase] = 1'b1;
  end

  assign mem_sel = (state == PSTART || state == PWAIT) ?
                   SEL_WIDTH'(phase) + SEL_WIDTH'(1) : '0;
  assign busy    = (state != IDLE) && (state != DONE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Bench for rc4_phase_sequencer: 4 phases, 8-bit key, keys 0..3, 16-cycle
// watchdog. A cycle table covers the happy path, a stray strobe and DONE
// handling; hand sequences cover retry, exhaustion, timeout, abort and reset.
module tb_rc4_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, abort, done_ack, key_pass;
  logic [3:0] phase_finish, phase_start;
  logic [2:0] mem_sel;
  logic [7:0] key;
  logic       busy, done, key_found, exhausted, timeout_err;

  int checks = 0;
  int failures = 0;

  rc4_phase_sequencer #(
    .NUM_PHASES(4), .KEY_WIDTH(8), .KEY_FIRST(0), .KEY_LAST(3), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .done_ack(done_ack),
    .phase_finish(phase_finish), .key_pass(key_pass), .phase_start(phase_start),
    .mem_sel(mem_sel), .key(key), .busy(busy), .done(done), .key_found(key_found),
    .exhausted(exhausted), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // status = {busy, done, key_found, exhausted, timeout_err}
  localparam logic [4:0] ST_IDLE = 5'b00000;
  localparam logic [4:0] ST_BUSY = 5'b10000;
  localparam logic [4:0] ST_KF   = 5'b01100;

  typedef struct {
    logic       start, abort, ack;
    logic [3:0] fin;
    logic       pass;
    logic [3:0] ps;
    logic [2:0] ms;
    logic [7:0] key;
    logic [4:0] st;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t v(input logic s, input logic a, input logic k,
                             input logic [3:0] f, input logic p,
                             input logic [3:0] ps, input logic [2:0] ms,
                             input logic [7:0] ky, input logic [4:0] st);
    vec_t r;
    r.start = s; r.abort = a; r.ack = k; r.fin = f; r.pass = p;
    r.ps = ps; r.ms = ms; r.key = ky; r.st = st;
    return r;
  endfunction

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] status();
    return {busy, done, key_found, exhausted, timeout_err};
  endfunction

  // Runs all four phases for one key, each engine finishing 3 cycles after
  // its start pulse; the verdict is given with the last finish strobe.
  task automatic run_pass(input logic pass, input logic [7:0] k);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("pass k%0d p%0d start", k, p),
          {17'b0, phase_start, mem_sel, key}, {17'b0, 4'(1 << p), 3'(p + 1), k});
      clk1(); clk1(); clk1();
      phase_finish = 4'(1 << p);
      key_pass     = pass;
      clk1();
      phase_finish = '0;
      key_pass     = 1'b0;
    end
  endtask

  initial begin
    //            s a k fin  p   ps    ms  key  status
    tbl[0]  = v(1,0,0,4'h0,0, 4'h1, 3'd1, 8'd0, ST_BUSY);
    tbl[1]  = v(0,0,0,4'h0,0, 4'h0, 3'd1, 8'd0, ST_BUSY);
    tbl[2]  = v(0,0,0,4'h8,1, 4'h0, 3'd1, 8'd0, ST_BUSY); // stray finish[3]
    tbl[3]  = v(0,0,0,4'h0,0, 4'h0, 3'd1, 8'd0, ST_BUSY);
    tbl[4]  = v(0,0,0,4'h1,0, 4'h2, 3'd2, 8'd0, ST_BUSY);
    tbl[5]  = v(0,0,0,4'h0,0, 4'h0, 3'd2, 8'd0, ST_BUSY);
    tbl[6]  = v(0,0,0,4'h0,0, 4'h0, 3'd2, 8'd0, ST_BUSY);
    tbl[7]  = v(0,0,0,4'h0,0, 4'h0, 3'd2, 8'd0, ST_BUSY);
    tbl[8]  = v(0,0,0,4'h2,0, 4'h4, 3'd3, 8'd0, ST_BUSY);
    tbl[9]  = v(0,0,0,4'h0,0, 4'h0, 3'd3, 8'd0, ST_BUSY);
    tbl[10] = v(0,0,0,4'h0,0, 4'h0, 3'd3, 8'd0, ST_BUSY);
    tbl[11] = v(0,0,0,4'h0,0, 4'h0, 3'd3, 8'd0, ST_BUSY);
    tbl[12] = v(0,0,0,4'h4,0, 4'h8, 3'd4, 8'd0, ST_BUSY);
    tbl[13] = v(0,0,0,4'h0,0, 4'h0, 3'd4, 8'd0, ST_BUSY);
    tbl[14] = v(0,0,0,4'h0,0, 4'h0, 3'd4, 8'd0, ST_BUSY);
    tbl[15] = v(0,0,0,4'h0,0, 4'h0, 3'd4, 8'd0, ST_BUSY);
    tbl[16] = v(0,0,0,4'h8,1, 4'h0, 3'd0, 8'd0, ST_KF);
    tbl[17] = v(1,1,0,4'h0,0, 4'h0, 3'd0, 8'd0, ST_KF);   // start/abort ignored in DONE
    tbl[18] = v(0,0,1,4'h0,0, 4'h0, 3'd0, 8'd0, ST_IDLE); // ack -> IDLE

    rst = 1'b1; start = 1'b0; abort = 1'b0; done_ack = 1'b0;
    phase_finish = '0; key_pass = 1'b0;
    clk1(); clk1();
    chk("reset", {12'b0, phase_start, mem_sel, key, status()}, 32'h0);
    rst = 1'b0;

    // Happy path table.
    for (int i = 0; i < 19; i++) begin
      start = tbl[i].start; abort = tbl[i].abort; done_ack = tbl[i].ack;
      phase_finish = tbl[i].fin; key_pass = tbl[i].pass;
      clk1();
      chk($sformatf("vec%0d", i),
          {12'b0, phase_start, mem_sel, key, status()},
          {12'b0, tbl[i].ps, tbl[i].ms, tbl[i].key, tbl[i].st});
    end
    start = 1'b0; abort = 1'b0; done_ack = 1'b0; phase_finish = '0; key_pass = 1'b0;

    // Retry: fail keys 0 and 1, pass key 2.
    start = 1'b1; clk1(); start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      run_pass(1'b0, 8'(k));
      chk($sformatf("retry next_key %0d", k), {24'b0, mem_sel, status()}, {24'b0, 3'd0, ST_BUSY});
      clk1();
    end
    run_pass(1'b1, 8'd2);
    chk("retry done", {19'b0, key, status()}, {19'b0, 8'd2, ST_KF});
    done_ack = 1'b1; clk1(); done_ack = 1'b0;
    chk("retry ack", {27'b0, status()}, {27'b0, ST_IDLE});

    // Exhaustion: every key fails.
    start = 1'b1; clk1(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      run_pass(1'b0, 8'(k));
      if (k < 3) clk1();
    end
    chk("exhaust done", {19'b0, key, status()}, {19'b0, 8'd3, 5'b01010});
    clk1(); clk1();
    chk("exhaust hold", {16'b0, mem_sel, key, status()}, {16'b0, 3'd0, 8'd3, 5'b01010});
    done_ack = 1'b1; clk1(); done_ack = 1'b0;
    chk("exhaust ack", {27'b0, status()}, {27'b0, ST_IDLE});

    // Timeout: engine 1 never finishes.
    start = 1'b1; clk1(); start = 1'b0;
    clk1(); clk1(); clk1();
    phase_finish = 4'h1; clk1(); phase_finish = '0;
    chk("timeout pstart1", {25'b0, phase_start, mem_sel}, {25'b0, 4'h2, 3'd2});
    clk1(); // first PWAIT(1) cycle
    repeat (15) clk1();
    chk("timeout still waiting", {24'b0, mem_sel, status()}, {24'b0, 3'd2, ST_BUSY});
    clk1();
    chk("timeout done", {24'b0, mem_sel, status()}, {24'b0, 3'd0, 5'b01001});
    done_ack = 1'b1; clk1(); done_ack = 1'b0;
    chk("timeout ack", {27'b0, status()}, {27'b0, ST_IDLE});

    // Abort in PWAIT(2) together with finish[2].
    start = 1'b1; clk1(); start = 1'b0;
    for (int p = 0; p < 2; p++) begin
      clk1(); clk1(); clk1();
      phase_finish = 4'(1 << p); clk1(); phase_finish = '0;
    end
    clk1();
    chk("abort in pwait2", {24'b0, mem_sel, status()}, {24'b0, 3'd3, ST_BUSY});
    abort = 1'b1; phase_finish = 4'h4; clk1(); abort = 1'b0; phase_finish = '0;
    chk("abort idle", {20'b0, phase_start, mem_sel, status()}, {20'b0, 4'h0, 3'd0, ST_IDLE});
    clk1();
    chk("abort no start3", {20'b0, phase_start, mem_sel, status()}, {20'b0, 4'h0, 3'd0, ST_IDLE});

    // Reset mid-PWAIT on the second key.
    start = 1'b1; clk1(); start = 1'b0;
    run_pass(1'b0, 8'd0);
    clk1(); clk1();
    chk("pre-reset pwait", {16'b0, mem_sel, key, status()}, {16'b0, 3'd1, 8'd1, ST_BUSY});
    rst = 1'b1; clk1(); rst = 1'b0;
    chk("mid reset", {12'b0, phase_start, mem_sel, key, status()}, 32'h0);
    clk1();
    chk("post reset idle", {12'b0, phase_start, mem_sel, key, status()}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rc4_phase_sequencer.md
RC4_PHASE_SEQUENCER -- requirements
Module: rc4_phase_sequencer

Interface
REQ-001 SHALL have parameter NUM_PHASES, default 4; number of sequenced sub-engines (init, shuffle A, shuffle B, decrypt, ...), legal range 2..8.
REQ-002 SHALL have parameter KEY_WIDTH, default 24; width of the key candidate.
REQ-003 SHALL have parameter KEY_FIRST, default 0; first key candidate tried.
REQ-004 SHALL have parameter KEY_LAST, default 2**KEY_WIDTH-1; last key candidate tried, with KEY_LAST >= KEY_FIRST.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 0; per-phase watchdog limit, where 0 disables the watchdog.
REQ-006 SHALL have derived width SEL_WIDTH = $clog2(NUM_PHASES+1).
REQ-007 SHALL have port clk, input, 1 bit; clock.
REQ-008 SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-009 SHALL have port start, input, 1 bit; begins a key search, honoured only in IDLE.
REQ-010 SHALL have port abort, input, 1 bit; cancels an in-progress search.
REQ-011 SHALL have port done_ack, input, 1 bit; releases DONE.
REQ-012 SHALL have port phase_finish, input, NUM_PHASES bits; bit p is the finish strobe from engine p.
REQ-013 SHALL have port key_pass, input, 1 bit; verdict of the last engine, sampled together with phase_finish[NUM_PHASES-1].
REQ-014 SHALL have port phase_start, output, NUM_PHASES bits; one-cycle start pulse to engine p.
REQ-015 SHALL have port mem_sel, output, SEL_WIDTH bits; shared-memory mux select: 0 when no phase is active, p+1 during phase p.
REQ-016 SHALL have port key, output, KEY_WIDTH bits; current key candidate.
REQ-017 SHALL have ports busy, done, key_found, exhausted and timeout_err, outputs, 1 bit each; status.

Function
REQ-018 SHALL implement states IDLE, PSTART(p), PWAIT(p), NEXT_KEY and DONE, with p held in an internal phase index.
REQ-019 SHALL, in IDLE with start=1, load key<=KEY_FIRST and p<=0 and go to PSTART(0); otherwise it stays in IDLE.
REQ-020 SHALL, in PSTART(p), assert phase_start[p]=1 for exactly that one cycle and then go to PWAIT(p); all other phase_start bits are 0.
REQ-021 SHALL drive mem_sel=p+1 throughout PSTART(p) and PWAIT(p), and mem_sel=0 in IDLE, NEXT_KEY and DONE.
REQ-022 SHALL, in PWAIT(p) with phase_finish[p]=1 and p<NUM_PHASES-1, go to PSTART(p+1).
REQ-023 SHALL, in PWAIT(NUM_PHASES-1) with the finish strobe asserted, act on key_pass as follows:
  - key_pass=1: go to DONE and set key_found=1;
  - key_pass=0 and key==KEY_LAST: go to DONE and set exhausted=1;
  - otherwise: go to NEXT_KEY.
REQ-024 SHALL, in NEXT_KEY, update key<=key+1 and p<=0 and go to PSTART(0); each retry therefore costs 2 cycles of overhead.
REQ-025 SHALL ignore phase_finish bits other than bit p in PWAIT(p), and all phase_finish bits in any other state.
REQ-026 SHALL, when TIMEOUT_CYCLES>0, count cycles spent in PWAIT(p), clearing the count on entry.
REQ-027 SHALL, when that count reaches TIMEOUT_CYCLES without a finish strobe, go to DONE and set timeout_err=1; a finish strobe arriving on the same cycle wins over the timeout.
REQ-028 SHALL, on abort=1 in PSTART, PWAIT or NEXT_KEY, go to IDLE on the next cycle without raising done or any flag.
REQ-029 SHALL give abort priority over finish, over timeout and over start.
REQ-030 SHALL ignore abort in IDLE and in DONE.
REQ-031 SHALL assert busy=1 in every state except IDLE and DONE.
REQ-032 SHALL assert done=1 only in DONE.
REQ-033 SHALL, in DONE, hold key, key_found, exhausted and timeout_err stable; exactly one of the three flags is 1.
REQ-034 SHALL, in DONE with done_ack=1, clear all flags and go to IDLE; start is ignored while in DONE.
REQ-035 SHALL never wrap key past KEY_LAST, including when KEY_LAST=2**KEY_WIDTH-1.
REQ-036 SHALL decode phase_start and mem_sel from registered state only, so they are glitch-free, with no combinational path from any input to any output.

Reset
REQ-037 SHALL, on rst=1 at a clock edge, enter IDLE and drive phase_start=0, mem_sel=0, key=KEY_FIRST, busy=0, done=0, key_found=0, exhausted=0 and timeout_err=0, with the watchdog count cleared.
REQ-038 SHALL let reset override every input and abort any search in progress, including a reset asserted mid-phase.

Verification
REQ-039 SHALL be verified with NUM_PHASES=4, KEY_WIDTH=8, KEY_FIRST=0, KEY_LAST=3 and TIMEOUT_CYCLES=16 covering these scenarios:
  - Happy path: start, each engine finishes 3 cycles after its start, key_pass=1 on key 0 -> phase_start pulses bits 0,1,2,3 in order; mem_sel steps 1,2,3,4; done=1, key_found=1, key=0.
  - Retry: key_pass=0 for keys 0 and 1, 1 for key 2 -> three full phase passes; done with key=2, key_found=1.
  - Exhaustion: key_pass always 0 -> done with key=3, exhausted=1, key_found=0, no fourth increment.
  - Timeout: engine 1 never finishes -> done 16 cycles after entering PWAIT(1), timeout_err=1, mem_sel=0.
  - Abort: abort in PWAIT(2) on the same cycle as phase_finish[2] -> IDLE next cycle, done=0, no phase_start[3].
  - Stray and ack: phase_finish[3] pulsed during PWAIT(0) -> ignored; done_ack in DONE -> IDLE and flags cleared; rst mid-PWAIT -> all outputs at reset values.
